// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module  : keypad_scan
// Brief   : 4x4 matrix keypad scanner with press/release debounce, emitting
//           a hex key code and a one-cycle strobe. Optional auto-repeat while
//           a key is held is enabled by defining KEYPAD_AUTOREPEAT_EN.
// Rev     : 1.0  initial release
// ============================================================================
module keypad_scan #(
    parameter int SCAN_DIV     = 24000,
    parameter int DEBOUNCE_CYC = 480000
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYC   = 6000000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SD_DB_MAX = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int MAX_P = (REPEAT_CYC > SD_DB_MAX) ? REPEAT_CYC : SD_DB_MAX;
`else
    localparam int MAX_P = SD_DB_MAX;
`endif
    localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif

    typedef enum logic [1:0] {
        ST_SCAN = 2'd0,
        ST_PDEB = 2'd1,
        ST_HELD = 2'd2,
        ST_RDEB = 2'd3
    } state_t;

    state_t           r_state;
    logic [3:0]       r_sync1;
    logic [3:0]       r_rs;
    logic [1:0]       r_col_idx;
    logic [1:0]       r_row_idx;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]       w_low_idx;
    logic             w_any_low;
    logic             w_tracked_high;
    logic [1:0]       w_next_idx;
    logic [3:0]       w_next_col;
    logic [CNT_W-1:0] w_cnt_inc;

    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Lowest-index low row wins when several rows read low together.
    always_comb begin
        w_low_idx = 2'd0;
        if (!r_rs[0])      w_low_idx = 2'd0;
        else if (!r_rs[1]) w_low_idx = 2'd1;
        else if (!r_rs[2]) w_low_idx = 2'd2;
        else               w_low_idx = 2'd3;
    end

    assign w_any_low      = ~&r_rs;
    assign w_tracked_high = r_rs[r_row_idx];
    assign w_next_idx     = r_col_idx + 2'd1;
    assign w_next_col     = ~(4'b0001 << w_next_idx);
    assign w_cnt_inc      = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 4'hF;
            r_rs    <= 4'hF;
        end else begin
            r_sync1 <= row;
            r_rs    <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_SCAN;
            r_col_idx <= 2'd0;
            r_row_idx <= 2'd0;
            r_cnt     <= '0;
            col       <= 4'b1110;
            key       <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (r_state)
                ST_SCAN: begin
                    if (r_cnt == SCAN_LAST) begin
                        r_cnt <= '0;
                        if (w_any_low) begin
                            r_row_idx <= w_low_idx;
                            r_state   <= ST_PDEB;
                        end else begin
                            r_col_idx <= w_next_idx;
                            col       <= w_next_col;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_PDEB: begin
                    if (w_tracked_high) begin
                        r_state   <= ST_SCAN;
                        r_cnt     <= '0;
                        r_col_idx <= w_next_idx;
                        col       <= w_next_col;
                    end else if (r_cnt == DB_LAST) begin
                        r_state   <= ST_HELD;
                        r_cnt     <= '0;
                        key       <= keymap(r_row_idx, r_col_idx);
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_HELD: begin
                    if (w_tracked_high) begin
                        r_state <= ST_RDEB;
                        r_cnt   <= '0;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (r_cnt == REP_LAST) begin
                        r_cnt     <= '0;
                        key_valid <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
`endif
                end
                ST_RDEB: begin
                    // Any low reading during release debounce means the key is still down.
                    if (!w_tracked_high) begin
                        r_state <= ST_HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        r_state   <= ST_SCAN;
                        r_cnt     <= '0;
                        key_held  <= 1'b0;
                        r_col_idx <= w_next_idx;
                        col       <= w_next_col;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= ST_SCAN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
// Module  : tb_keypad_scan
// Brief   : Directed self-checking bench for keypad_scan with a behavioural
//           4x4 key matrix driven from the scanner's column outputs.
// Rev     : 1.0  initial release
// ============================================================================
module tb_keypad_scan;

    logic        clk;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pmask;   // bit r*4+c = key at row r / column c is pressed

    int tests;
    int fails;
    int consec;
    logic prev_kv;

    keypad_scan #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CYC (8)
`ifdef KEYPAD_AUTOREPEAT_EN
        ,
        .REPEAT_CYC   (20)
`endif
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .row       (row),
        .col       (col),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pmask[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    initial begin
        consec  = 0;
        prev_kv = 1'b0;
    end
    always @(negedge clk) begin
        if (key_valid && prev_kv) consec = consec + 1;
        prev_kv = key_valid;
    end

    task automatic wait_strobe(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (key_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_held(input logic val, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (key_held === val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_strobes(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (key_valid) n++;
        end
    endtask

    // Returns at the first negedge on which column 3 is newly active.
    task automatic wait_col3(output bit ok);
        bit left;
        ok = 1'b0;
        left = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (col !== 4'b0111) left = 1'b1;
            else if (left) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        pmask = 16'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_col", {4'h0, col}, 8'h0E);
        chk("reset_key", {4'h0, key}, 8'h00);
        chk("reset_valid", {7'h0, key_valid}, 8'h00);
        chk("reset_held", {7'h0, key_held}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("col_dwell", {4'h0, col}, 8'h0E);
        @(negedge clk);
        chk("col_advance", {4'h0, col}, 8'h0D);
    endtask

    task automatic test_press;
        bit ok;
        int n;
        pmask = 16'h0400;   // row2 / col2
        wait_strobe(60, ok);
        chk("press_strobe", {7'h0, ok}, 8'h01);
        chk("press_key", {4'h0, key}, 8'h09);
        chk("press_held", {7'h0, key_held}, 8'h01);
        count_strobes(40, n);
        chk("press_single_strobe", n[7:0], 8'h00);
        chk("press_held_long", {7'h0, key_held}, 8'h01);
        pmask = 16'h0;
        repeat (8) @(negedge clk);
        chk("release_held_early", {7'h0, key_held}, 8'h01);
        wait_held(1'b0, 10, ok);
        chk("release_held_clear", {7'h0, ok}, 8'h01);
        chk("release_key_kept", {4'h0, key}, 8'h09);
    endtask

    task automatic test_bounce;
        bit ok;
        int n;
        wait_col3(ok);
        chk("bounce_col3_seen", {7'h0, ok}, 8'h01);
        pmask = 16'h0008;   // row0 / col3
        repeat (5) @(negedge clk);
        chk("bounce_col_frozen", {4'h0, col}, 8'h07);
        pmask = 16'h0;
        count_strobes(3, n);
        chk("bounce_no_strobe", n[7:0], 8'h00);
        chk("bounce_resume_col0", {4'h0, col}, 8'h0E);
        chk("bounce_not_held", {7'h0, key_held}, 8'h00);
    endtask

    task automatic test_multi;
        bit ok;
        int n;
        pmask = 16'h2000;   // row3 / col1
        wait_strobe(60, ok);
        chk("multi_first_strobe", {7'h0, ok}, 8'h01);
        chk("multi_first_key", {4'h0, key}, 8'h00);
        pmask = 16'h2001;   // add row0 / col0
        count_strobes(30, n);
        chk("multi_ignored", n[7:0], 8'h00);
        chk("multi_key_kept", {4'h0, key}, 8'h00);
        pmask = 16'h0001;
        wait_strobe(80, ok);
        chk("multi_rescan_strobe", {7'h0, ok}, 8'h01);
        chk("multi_rescan_key", {4'h0, key}, 8'h01);
        pmask = 16'h0;
        wait_held(1'b0, 40, ok);
        chk("multi_released", {7'h0, ok}, 8'h01);
    endtask

    task automatic test_glitch;
        bit ok;
        int n;
        int drops;
        pmask = 16'h0010;   // row1 / col0
        wait_strobe(60, ok);
        chk("glitch_strobe", {7'h0, ok}, 8'h01);
        chk("glitch_key", {4'h0, key}, 8'h04);
        pmask = 16'h0;
        repeat (3) @(negedge clk);
        pmask = 16'h0010;
        n = 0;
        drops = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (key_valid) n++;
            if (!key_held) drops++;
        end
        chk("glitch_held_kept", drops[7:0], 8'h00);
        chk("glitch_no_strobe", n[7:0], 8'h00);
        pmask = 16'h0;
        wait_held(1'b0, 40, ok);
        chk("glitch_released", {7'h0, ok}, 8'h01);
    endtask

    task automatic test_reset_midpress;
        bit ok;
        int n;
        wait_col3(ok);
        chk("midpress_col3_seen", {7'h0, ok}, 8'h01);
        pmask = 16'h8000;   // row3 / col3
        repeat (5) @(negedge clk);
        chk("midpress_frozen", {4'h0, col}, 8'h07);
        rst = 1'b1;
        #1;
        chk("midpress_col", {4'h0, col}, 8'h0E);
        chk("midpress_key", {4'h0, key}, 8'h00);
        repeat (2) @(negedge clk);
        pmask = 16'h0;
        rst = 1'b0;
        count_strobes(40, n);
        chk("midpress_no_strobe", n[7:0], 8'h00);
        chk("midpress_not_held", {7'h0, key_held}, 8'h00);
    endtask

`ifdef KEYPAD_AUTOREPEAT_EN
    task automatic test_autorepeat;
        bit ok;
        int bad;
        pmask = 16'h0040;   // row1 / col2
        wait_strobe(60, ok);
        chk("rep_first_strobe", {7'h0, ok}, 8'h01);
        chk("rep_first_key", {4'h0, key}, 8'h06);
        bad = 0;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            if (key_valid !== ((i % 20) == 0)) begin
                bad++;
                $display("FAIL rep_timing: cycle +%0d got %0b expected %0b",
                         i, key_valid, ((i % 20) == 0));
            end
            if (key !== 4'h6) bad++;
        end
        chk("rep_pattern_errors", bad[7:0], 8'h00);
        rst = 1'b1;
        #1;
        chk("rep_reset_key", {4'h0, key}, 8'h00);
        chk("rep_reset_held", {7'h0, key_held}, 8'h00);
        chk("rep_reset_valid", {7'h0, key_valid}, 8'h00);
        chk("rep_reset_col", {4'h0, col}, 8'h0E);
        pmask = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        pmask = 16'h0;
        test_reset;
        test_press;
        test_bounce;
        test_multi;
        test_glitch;
        test_reset_midpress;
`ifdef KEYPAD_AUTOREPEAT_EN
        test_autorepeat;
`endif
        #1;
        chk("no_back_to_back_valid", consec[7:0], 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
